// File: rtl/reg_scoreboard.sv
// Register scoreboard beside the D stage: per-register write countdowns, RAW/WAW stall, forwarding flags, flush pruning.
// Latency: stall_o/fwd_hit_o are combinational from inputs and state; busy_vec_o follows state; pending_cnt_o is registered.
// Backpressure: stall_o holds D/IF; a stalled or flushed issue leaves the counters untouched apart from normal countdown/prune.
// Ports:
//   clk_i, rst_i                    clock (rising edge), asynchronous active-high reset
//   issue_valid_i, issue_wr_i       D stage presents an instruction / it writes a register
//   issue_dst_i, issue_lat_i        destination register, cycles until its result is available
//   src_valid_i, src_addr_i         per-operand read flags, packed operand addresses
//   flush_i                         branch/jump flush of younger work
//   stall_o, fwd_hit_o              hazard stall, per-operand forwarding select
//   busy_vec_o, pending_cnt_o       per-register pending bit, count of pending registers
module reg_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MAX_LAT    = 4,
  parameter int FWD_EN     = 1,
  parameter int FLUSH_THR  = 3,
  localparam int NREG      = 2 ** REG_ADDR_W,
  localparam int LAT_W     = $clog2(MAX_LAT + 1),
  localparam int CNT_W     = REG_ADDR_W + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_wr_i,
  input  logic [REG_ADDR_W-1:0]         issue_dst_i,
  input  logic [LAT_W-1:0]              issue_lat_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
  input  logic                          flush_i,
  output logic                          stall_o,
  output logic [NUM_SRC-1:0]            fwd_hit_o,
  output logic [NREG-1:0]               busy_vec_o,
  output logic [CNT_W-1:0]              pending_cnt_o
);

  logic [LAT_W-1:0]      cnt_q [NREG];
  logic [LAT_W-1:0]      cnt_d [NREG];
  logic [CNT_W-1:0]      pend_q;
  logic [CNT_W-1:0]      pend_d;
  logic [LAT_W-1:0]      eff_lat;
  logic [NUM_SRC-1:0]    src_blk;
  logic [REG_ADDR_W-1:0] src_a;
  logic [LAT_W-1:0]      src_c;
  logic                  waw;
  logic                  accept;

  // Latency 0 would never be seen as pending; over-range values saturate.
  always_comb begin
    eff_lat = issue_lat_i;
    if (issue_lat_i == '0) begin
      eff_lat = LAT_W'(1);
    end else if (int'(issue_lat_i) > MAX_LAT) begin
      eff_lat = LAT_W'(MAX_LAT);
    end
  end

  // A count of 1 means the result lands at the end of this cycle, so the
  // bypass network can supply it instead of waiting.
  always_comb begin
    src_blk   = '0;
    fwd_hit_o = '0;
    src_a     = '0;
    src_c     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a = src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
      src_c = cnt_q[src_a];
      if (src_valid_i[i] && (src_a != '0)) begin
        if ((FWD_EN != 0) && (src_c == LAT_W'(1))) begin
          fwd_hit_o[i] = 1'b1;
        end else if (src_c != '0) begin
          src_blk[i] = 1'b1;
        end
      end
    end
  end

  // An older write finishing after this one would clobber the newer value.
  assign waw     = issue_wr_i && (issue_dst_i != '0) && (cnt_q[issue_dst_i] > eff_lat);
  assign stall_o = issue_valid_i && ((|src_blk) || waw);
  assign accept  = issue_valid_i && !stall_o && !flush_i && issue_wr_i && (issue_dst_i != '0);

  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (accept && (issue_dst_i == REG_ADDR_W'(r))) begin
        cnt_d[r] = eff_lat;
      end else if (flush_i && (int'(cnt_q[r]) >= FLUSH_THR)) begin
        // Long-latency entries belong to squashed younger instructions.
        cnt_d[r] = '0;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (cnt_d[r] != '0) begin
        pend_d = pend_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    busy_vec_o = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec_o[r] = (cnt_q[r] != '0);
    end
  end

  assign pending_cnt_o = pend_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  typedef struct {
    logic       iv;
    logic       iw;
    logic [4:0] dst;
    logic [2:0] lat;
    logic [1:0] sv;
    logic [4:0] a0;
    logic [4:0] a1;
    logic       fl;
  } stim_t;

  typedef struct {
    logic        stall;
    logic [1:0]  fwd;
    logic [31:0] busy;
    logic [5:0]  pcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr, flush;
  logic [4:0]  issue_dst;
  logic [2:0]  issue_lat;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic        stall, nf_stall;
  logic [1:0]  fwd_hit, nf_fwd_hit;
  logic [31:0] busy_vec, nf_busy_vec;
  logic [5:0]  pending_cnt, nf_pending_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  reg_scoreboard #(.FWD_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_wr_i(issue_wr),
    .issue_dst_i(issue_dst), .issue_lat_i(issue_lat), .src_valid_i(src_valid),
    .src_addr_i(src_addr), .flush_i(flush), .stall_o(stall), .fwd_hit_o(fwd_hit),
    .busy_vec_o(busy_vec), .pending_cnt_o(pending_cnt)
  );

  reg_scoreboard #(.FWD_EN(0)) dut_nf (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_wr_i(issue_wr),
    .issue_dst_i(issue_dst), .issue_lat_i(issue_lat), .src_valid_i(src_valid),
    .src_addr_i(src_addr), .flush_i(flush), .stall_o(nf_stall), .fwd_hit_o(nf_fwd_hit),
    .busy_vec_o(nf_busy_vec), .pending_cnt_o(nf_pending_cnt)
  );

  function automatic stim_t mk(logic iv, logic iw, logic [4:0] dst, logic [2:0] lat,
                               logic [1:0] sv, logic [4:0] a0, logic [4:0] a1, logic fl);
    stim_t s;
    s.iv = iv; s.iw = iw; s.dst = dst; s.lat = lat;
    s.sv = sv; s.a0 = a0; s.a1 = a1; s.fl = fl;
    return s;
  endfunction

  function automatic exp_t ex(logic st, logic [1:0] fw, logic [31:0] bz, logic [5:0] pc);
    exp_t e;
    e.stall = st; e.fwd = fw; e.busy = bz; e.pcnt = pc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    issue_valid = s.iv;
    issue_wr    = s.iw;
    issue_dst   = s.dst;
    issue_lat   = s.lat;
    src_valid   = s.sv;
    src_addr    = {s.a1, s.a0};
    flush       = s.fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives each row in the cycle before a rising edge, samples mid-low-phase.
  task automatic run_rows(input string name, input stim_t s [$], input exp_t e [$], input bit use_nf);
    exp_t x;
    logic        g_st;
    logic [1:0]  g_fw;
    logic [31:0] g_bz;
    logic [5:0]  g_pc;
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      sb.push_back(e[i]);
      #2;
      x    = sb.pop_front();
      g_st = use_nf ? nf_stall       : stall;
      g_fw = use_nf ? nf_fwd_hit     : fwd_hit;
      g_bz = use_nf ? nf_busy_vec    : busy_vec;
      g_pc = use_nf ? nf_pending_cnt : pending_cnt;
      checks++;
      if (g_st !== x.stall) begin
        errors++; $display("FAIL %s stall row %0d: got %b want %b", name, i, g_st, x.stall);
      end
      checks++;
      if (g_fw !== x.fwd) begin
        errors++; $display("FAIL %s fwd_hit row %0d: got %b want %b", name, i, g_fw, x.fwd);
      end
      checks++;
      if (g_bz !== x.busy) begin
        errors++; $display("FAIL %s busy_vec row %0d: got %h want %h", name, i, g_bz, x.busy);
      end
      checks++;
      if (g_pc !== x.pcnt) begin
        errors++; $display("FAIL %s pending_cnt row %0d: got %0d want %0d", name, i, g_pc, x.pcnt);
      end
    end
  endtask

  task automatic test_reset();
    exp_t x;
    rst = 1'b1;
    apply(mk(1, 0, 0, 0, 2'b01, 5'd5, 0, 0));
    sb.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    #3;
    x = sb.pop_front();
    checks++;
    if (stall !== x.stall) begin errors++; $display("FAIL reset stall: got %b want %b", stall, x.stall); end
    checks++;
    if (busy_vec !== x.busy) begin errors++; $display("FAIL reset busy_vec: got %h want %h", busy_vec, x.busy); end
    checks++;
    if (pending_cnt !== x.pcnt) begin errors++; $display("FAIL reset pending_cnt: got %0d want %0d", pending_cnt, x.pcnt); end
    do_reset();
    // Reset asserted between edges must drop a pending entry at once.
    @(negedge clk); apply(mk(1, 1, 5'd3, 3'd4, 2'b00, 0, 0, 0));
    @(negedge clk); apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
    sb.push_back(ex(0, 2'b00, 32'h8, 6'd1));
    #1;
    x = sb.pop_front();
    checks++;
    if (busy_vec !== x.busy) begin errors++; $display("FAIL midreset pre busy_vec: got %h want %h", busy_vec, x.busy); end
    rst = 1'b1;
    sb.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    #1;
    x = sb.pop_front();
    checks++;
    if (busy_vec !== x.busy) begin errors++; $display("FAIL midreset busy_vec: got %h want %h", busy_vec, x.busy); end
    checks++;
    if (pending_cnt !== x.pcnt) begin errors++; $display("FAIL midreset pending_cnt: got %0d want %0d", pending_cnt, x.pcnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw_fwd();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd3, 3'd3, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(1, 2'b00, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(1, 2'b00, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(0, 2'b01, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    run_rows("raw_fwd", s, e, 0);
  endtask

  task automatic test_no_fwd();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd3, 3'd3, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(1, 2'b00, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(1, 2'b00, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(1, 2'b00, 32'h8, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd3, 0, 0));       e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    run_rows("no_fwd", s, e, 1);
  endtask

  task automatic test_r0();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd0, 3'd4, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b11, 5'd0, 5'd0, 0));    e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b11, 5'd0, 5'd0, 0));    e.push_back(ex(0, 2'b00, 32'h0, 6'd0));
    run_rows("r0", s, e, 0);
  endtask

  task automatic test_waw();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd7, 3'd4, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0,  6'd0));
    s.push_back(mk(1, 1, 5'd7, 3'd1, 2'b00, 0, 0, 0));    e.push_back(ex(1, 2'b00, 32'h80, 6'd1));
    s.push_back(mk(1, 1, 5'd7, 3'd1, 2'b00, 0, 0, 0));    e.push_back(ex(1, 2'b00, 32'h80, 6'd1));
    s.push_back(mk(1, 1, 5'd7, 3'd1, 2'b00, 0, 0, 0));    e.push_back(ex(1, 2'b00, 32'h80, 6'd1));
    s.push_back(mk(1, 1, 5'd7, 3'd1, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h80, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd7, 0, 0));       e.push_back(ex(0, 2'b01, 32'h80, 6'd1));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));          e.push_back(ex(0, 2'b00, 32'h0,  6'd0));
    run_rows("waw", s, e, 0);
  endtask

  task automatic test_flush();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd4,  3'd4, 2'b00, 0, 0, 0));   e.push_back(ex(0, 2'b00, 32'h0,   6'd0));
    s.push_back(mk(1, 1, 5'd11, 3'd4, 2'b00, 0, 0, 0));   e.push_back(ex(0, 2'b00, 32'h10,  6'd1));
    s.push_back(mk(1, 1, 5'd2,  3'd4, 2'b00, 0, 0, 0));   e.push_back(ex(0, 2'b00, 32'h810, 6'd2));
    s.push_back(mk(1, 1, 5'd9,  3'd2, 2'b00, 0, 0, 1));   e.push_back(ex(0, 2'b00, 32'h814, 6'd3));
    s.push_back(mk(0, 0, 0, 0, 2'b01, 5'd4, 0, 0));       e.push_back(ex(0, 2'b01, 32'h10,  6'd1));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));          e.push_back(ex(0, 2'b00, 32'h0,   6'd0));
    run_rows("flush", s, e, 0);
  endtask

  task automatic test_lat_clamp();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd9, 3'd0, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0,   6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b10, 0, 5'd9, 0));       e.push_back(ex(0, 2'b10, 32'h200, 6'd1));
    s.push_back(mk(1, 1, 5'd9, 3'd7, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0,   6'd0));
    s.push_back(mk(1, 0, 0, 0, 2'b10, 0, 5'd9, 0));       e.push_back(ex(1, 2'b00, 32'h200, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b10, 0, 5'd9, 0));       e.push_back(ex(1, 2'b00, 32'h200, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b10, 0, 5'd9, 0));       e.push_back(ex(1, 2'b00, 32'h200, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b10, 0, 5'd9, 0));       e.push_back(ex(0, 2'b10, 32'h200, 6'd1));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));          e.push_back(ex(0, 2'b00, 32'h0,   6'd0));
    run_rows("lat_clamp", s, e, 0);
  endtask

  task automatic test_back_to_back();
    stim_t s [$];
    exp_t  e [$];
    do_reset();
    s.push_back(mk(1, 1, 5'd5, 3'd2, 2'b00, 0, 0, 0));    e.push_back(ex(0, 2'b00, 32'h0,  6'd0));
    s.push_back(mk(1, 1, 5'd5, 3'd2, 2'b01, 5'd5, 0, 0)); e.push_back(ex(1, 2'b00, 32'h20, 6'd1));
    s.push_back(mk(1, 1, 5'd5, 3'd2, 2'b01, 5'd5, 0, 0)); e.push_back(ex(0, 2'b01, 32'h20, 6'd1));
    s.push_back(mk(1, 0, 0, 0, 2'b01, 5'd5, 0, 0));       e.push_back(ex(1, 2'b00, 32'h20, 6'd1));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));          e.push_back(ex(0, 2'b00, 32'h20, 6'd1));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));          e.push_back(ex(0, 2'b00, 32'h0,  6'd0));
    run_rows("back_to_back", s, e, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw_fwd();
    test_no_fwd();
    test_r0();
    test_waw();
    test_flush();
    test_lat_clamp();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
